// File: rtl/boss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : boss_ctrl
//  Description : Boss sprite controller. Handles entry descent, horizontal
//                sweeping, hit counting with immunity frames, a sticky second
//                phase, volley requests, the dying blink and the terminal
//                dead state. Also renders the sprite coverage and ROM address
//                for the current scan pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module boss_ctrl #(
    parameter int          SPR_W     = 64,
    parameter int          SPR_H     = 96,
    parameter int          MAX_X     = 384,
    parameter int          HOME_X    = 192,
    parameter int          HOME_Y    = 100,
    parameter int          HP_W      = 10,
    parameter int          HP_INIT   = 1000,
    parameter int          TICK_MAX  = 4000,
    parameter int          IFRAMES   = 8,
    parameter int          FIRE_DIV  = 32,
    parameter int          DIE_TICKS = 64,
    parameter logic [11:0] KEY_COLOR = 12'hCCC
) (
    input  logic                               reset,
    input  logic                               clk_in,
    input  logic [25:0]                        speed_offset,
    input  logic [9:0]                         x,
    input  logic [9:0]                         y,
    input  logic                               is_hit,
    input  logic [11:0]                        rom_data,
    output logic [$clog2(SPR_W*SPR_H)-1:0]     rom_addr,
    output logic [9:0]                         boss_x,
    output logic [9:0]                         boss_y,
    output logic                               boss_on,
    output logic [HP_W-1:0]                    health,
    output logic                               phase,
    output logic                               fire_req,
    output logic                               die
);

    localparam int C_AW     = $clog2(SPR_W*SPR_H);
    localparam int C_HALF_W = SPR_W / 2;
    localparam int C_HALF_H = SPR_H / 2;
    localparam int C_XMAX   = MAX_X - C_HALF_W;
    localparam int C_IF_W   = $clog2(IFRAMES + 1);
    localparam int C_FC_W   = $clog2(FIRE_DIV);
    localparam int C_DC_W   = ($clog2(DIE_TICKS) < 3) ? 3 : $clog2(DIE_TICKS);

    typedef enum logic [2:0] {
        ENTER   = 3'd0,
        SWEEP_R = 3'd1,
        SWEEP_L = 3'd2,
        DYING   = 3'd3,
        DEAD    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [25:0]         cnt_q, cnt_d;
    logic [9:0]          bx_q, bx_d;
    logic [9:0]          by_q, by_d;
    logic [HP_W-1:0]     health_q, health_d;
    logic [C_IF_W-1:0]   ifr_q, ifr_d;
    logic [C_FC_W-1:0]   fc_q, fc_d;
    logic [C_DC_W-1:0]   dc_q, dc_d;
    logic                phase_q, phase_d;
    logic                fire_q, fire_d;

    logic [25:0]         w_lim;
    logic                w_tick;
    logic                w_sweep;
    logic                w_hit;
    logic [9:0]          w_step;
    logic [C_FC_W-1:0]   w_div_m1;

    // Tick prescaler: period limit with clamp, counter halted once dead
    always_comb begin
        w_lim  = (speed_offset >= 26'(TICK_MAX - 1)) ? 26'd1 : (26'(TICK_MAX) - speed_offset);
        w_tick = (state_q != DEAD) && (cnt_q == w_lim);
        cnt_d  = cnt_q;
        if (state_q != DEAD) begin
            cnt_d = (cnt_q >= w_lim) ? 26'd0 : (cnt_q + 26'd1);
        end
    end

    // Hit acceptance and immunity window; runs every cycle, not only on tick
    always_comb begin
        w_sweep  = (state_q == SWEEP_R) || (state_q == SWEEP_L);
        w_hit    = is_hit && w_sweep && (ifr_q == '0);
        health_d = (w_hit && (health_q != '0)) ? (health_q - 1'b1) : health_q;
        if (w_hit) begin
            ifr_d = C_IF_W'(IFRAMES);
        end else if (ifr_q != '0) begin
            ifr_d = ifr_q - 1'b1;
        end else begin
            ifr_d = ifr_q;
        end
    end

    // Next-state logic for the FSM, position, phase and volley counter
    always_comb begin
        state_d  = state_q;
        bx_d     = bx_q;
        by_d     = by_q;
        phase_d  = phase_q;
        fc_d     = fc_q;
        dc_d     = dc_q;
        fire_d   = 1'b0;
        w_step   = phase_q ? 10'd2 : 10'd1;
        w_div_m1 = phase_q ? C_FC_W'(FIRE_DIV/2 - 1) : C_FC_W'(FIRE_DIV - 1);
        if (w_tick) begin
            // Phase decision uses the health seen at this tick; step uses the old phase
            phase_d = phase_q | (health_q <= HP_W'(HP_INIT/2));
            case (state_q)
                ENTER: begin
                    by_d = by_q + 10'd1;
                    if (by_q + 10'd1 == 10'(HOME_Y)) begin
                        state_d = SWEEP_R;
                    end
                end
                SWEEP_R, SWEEP_L: begin
                    if (health_q == '0) begin
                        state_d = DYING;
                        dc_d    = '0;
                    end else begin
                        if (state_q == SWEEP_R) begin
                            if ({1'b0, bx_q} + {1'b0, w_step} > 11'(C_XMAX)) begin
                                bx_d    = 10'(C_XMAX);
                                state_d = SWEEP_L;
                            end else begin
                                bx_d = bx_q + w_step;
                            end
                        end else begin
                            if ({1'b0, bx_q} < 11'(C_HALF_W) + {1'b0, w_step}) begin
                                bx_d    = 10'(C_HALF_W);
                                state_d = SWEEP_R;
                            end else begin
                                bx_d = bx_q - w_step;
                            end
                        end
                        if (phase_d != phase_q) begin
                            fc_d = '0;
                        end else if (fc_q == w_div_m1) begin
                            fc_d   = '0;
                            fire_d = 1'b1;
                        end else begin
                            fc_d = fc_q + 1'b1;
                        end
                    end
                end
                DYING: begin
                    if (dc_q == C_DC_W'(DIE_TICKS - 1)) begin
                        state_d = DEAD;
                    end else begin
                        dc_d = dc_q + 1'b1;
                    end
                end
                DEAD: begin
                    state_d = DEAD;
                end
                default: begin
                    state_d = ENTER;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= ENTER;
            cnt_q    <= '0;
            bx_q     <= 10'(HOME_X);
            by_q     <= 10'(C_HALF_H);
            health_q <= HP_W'(HP_INIT);
            ifr_q    <= '0;
            fc_q     <= '0;
            dc_q     <= '0;
            phase_q  <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            health_q <= health_d;
            ifr_q    <= ifr_d;
            fc_q     <= fc_d;
            dc_q     <= dc_d;
            phase_q  <= phase_d;
            fire_q   <= fire_d;
        end
    end

    logic [10:0] w_x, w_y, w_bx, w_by, w_col, w_row;
    logic        w_cover;

    // Pixel coverage and ROM address; bounds rearranged to avoid subtraction wrap
    always_comb begin
        w_x     = {1'b0, x};
        w_y     = {1'b0, y};
        w_bx    = {1'b0, bx_q};
        w_by    = {1'b0, by_q};
        w_cover = (w_x + 11'(C_HALF_W) >= w_bx + 11'd1) && (w_x <= w_bx + 11'(C_HALF_W)) &&
                  (w_y + 11'(C_HALF_H) >= w_by + 11'd1) && (w_y <= w_by + 11'(C_HALF_H));
        w_col   = w_x + 11'(C_HALF_W) - 11'd1 - w_bx;
        w_row   = w_y + 11'(C_HALF_H) - 11'd1 - w_by;
        rom_addr = w_cover ? (C_AW'(w_col) + C_AW'(w_row) * C_AW'(SPR_W)) : '0;
        boss_on  = w_cover && (rom_data != KEY_COLOR) && (state_q != DEAD) &&
                   ((state_q != DYING) || !dc_q[2]);
    end

    assign boss_x   = bx_q;
    assign boss_y   = by_q;
    assign health   = health_q;
    assign phase    = phase_q;
    assign fire_req = fire_q;
    assign die      = (state_q == DEAD);

endmodule
`default_nettype wire

// File: tb/tb_boss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boss_ctrl
//  Description : Self-checking bench for boss_ctrl with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boss_ctrl;
    localparam int SPR_W = 64, SPR_H = 96, MAX_X = 384, HOME_X = 192, HOME_Y = 100;
    localparam int HP_W = 10, HP_INIT = 1000, TICK_MAX = 4000, IFRAMES = 8;
    localparam int FIRE_DIV = 32, DIE_TICKS = 64;
    localparam int S_ENTER = 0, S_SWR = 1, S_SWL = 2, S_DYING = 3, S_DEAD = 4;

    logic        reset = 1'b1;
    logic        clk_in = 1'b0;
    logic [25:0] speed_offset;
    logic [9:0]  x, y;
    logic        is_hit;
    logic [11:0] rom_data;
    logic [12:0] rom_addr;
    logic [9:0]  boss_x, boss_y;
    logic        boss_on;
    logic [9:0]  health;
    logic        phase, fire_req, die;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int m_cnt, m_st, m_x, m_y, m_hp, m_ph, m_if, m_fc, m_dc, m_fire, m_ticks;

    boss_ctrl dut (
        .reset(reset), .clk_in(clk_in), .speed_offset(speed_offset),
        .x(x), .y(y), .is_hit(is_hit), .rom_data(rom_data),
        .rom_addr(rom_addr), .boss_x(boss_x), .boss_y(boss_y), .boss_on(boss_on),
        .health(health), .phase(phase), .fire_req(fire_req), .die(die)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_cnt = 0; m_st = S_ENTER; m_x = HOME_X; m_y = SPR_H/2; m_hp = HP_INIT;
        m_ph = 0; m_if = 0; m_fc = 0; m_dc = 0; m_fire = 0; m_ticks = 0;
    endtask

    // One clock of the behavioural model, using the inputs present at the edge
    task automatic model_clock();
        int lim, ost, stp, div, nph;
        bit tk, hit;
        ost = m_st;
        lim = (int'(speed_offset) >= TICK_MAX - 1) ? 1 : TICK_MAX - int'(speed_offset);
        tk  = (ost != S_DEAD) && (m_cnt == lim);
        hit = (is_hit === 1'b1) && (ost == S_SWR || ost == S_SWL) && (m_if == 0);
        m_fire = 0;
        if (tk) begin
            m_ticks++;
            nph = (m_ph == 1 || m_hp <= HP_INIT/2) ? 1 : 0;
            stp = (m_ph == 1) ? 2 : 1;
            div = (m_ph == 1) ? FIRE_DIV/2 : FIRE_DIV;
            case (ost)
                S_ENTER: begin
                    m_y++;
                    if (m_y == HOME_Y) m_st = S_SWR;
                end
                S_SWR, S_SWL: begin
                    if (m_hp == 0) begin
                        m_st = S_DYING; m_dc = 0;
                    end else begin
                        if (ost == S_SWR) begin
                            if (m_x + stp > MAX_X - SPR_W/2) begin m_x = MAX_X - SPR_W/2; m_st = S_SWL; end
                            else m_x += stp;
                        end else begin
                            if (m_x - stp < SPR_W/2) begin m_x = SPR_W/2; m_st = S_SWR; end
                            else m_x -= stp;
                        end
                        if (nph != m_ph) m_fc = 0;
                        else begin
                            m_fc++;
                            if (m_fc == div) begin m_fc = 0; m_fire = 1; end
                        end
                    end
                end
                S_DYING: begin
                    m_dc++;
                    if (m_dc == DIE_TICKS) m_st = S_DEAD;
                end
                default: ;
            endcase
            m_ph = nph;
        end
        if (ost != S_DEAD) m_cnt = (m_cnt >= lim) ? 0 : m_cnt + 1;
        if (hit) begin
            if (m_hp > 0) m_hp--;
            m_if = IFRAMES;
        end else if (m_if > 0) m_if--;
    endtask

    function automatic bit e_cover();
        int xi, yi;
        xi = int'(x); yi = int'(y);
        return (xi >= m_x - SPR_W/2 + 1) && (xi <= m_x + SPR_W/2) &&
               (yi >= m_y - SPR_H/2 + 1) && (yi <= m_y + SPR_H/2);
    endfunction

    function automatic int e_addr();
        if (!e_cover()) return 0;
        return (int'(x) - (m_x - SPR_W/2 + 1)) + (int'(y) - (m_y - SPR_H/2 + 1)) * SPR_W;
    endfunction

    function automatic bit e_on();
        return e_cover() && (rom_data != 12'hCCC) && (m_st != S_DEAD) &&
               (m_st != S_DYING || ((m_dc / 4) % 2 == 0));
    endfunction

    task automatic run_cycle();
        @(posedge clk_in);
        model_clock();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        #1;
    endtask

    task automatic rand_inputs(input int hit_pct);
        int xv, yv;
        if ($urandom_range(0, 1) == 1) begin
            xv = m_x + int'($urandom_range(0, 80)) - 40;
            yv = m_y + int'($urandom_range(0, 110)) - 55;
        end else begin
            xv = int'($urandom_range(0, 1023));
            yv = int'($urandom_range(0, 1023));
        end
        if (xv < 0) xv = 0;
        if (yv < 0) yv = 0;
        if (xv > 1023) xv = 1023;
        if (yv > 1023) yv = 1023;
        x = 10'(xv);
        y = 10'(yv);
        rom_data = ($urandom_range(0, 2) == 0) ? 12'hCCC : 12'($urandom);
        is_hit = (int'($urandom_range(0, 99)) < hit_pct);
    endtask

    task automatic test_reset();
        speed_offset = 26'd3990; x = 10'd0; y = 10'd0; is_hit = 1'b0; rom_data = 12'h000;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_in);
        #1;
        n_vec++; if (boss_x !== 10'(HOME_X)) begin n_err++; $display("FAIL reset boss_x: got %0d want %0d", boss_x, HOME_X); end
        n_vec++; if (boss_y !== 10'(SPR_H/2)) begin n_err++; $display("FAIL reset boss_y: got %0d want %0d", boss_y, SPR_H/2); end
        n_vec++; if (health !== 10'(HP_INIT)) begin n_err++; $display("FAIL reset health: got %0d want %0d", health, HP_INIT); end
        n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL reset phase: got %b want 0", phase); end
        n_vec++; if (fire_req !== 1'b0) begin n_err++; $display("FAIL reset fire_req: got %b want 0", fire_req); end
        n_vec++; if (die !== 1'b0) begin n_err++; $display("FAIL reset die: got %b want 0", die); end
        n_vec++; if (boss_on !== 1'b0 || rom_addr !== 13'd0) begin n_err++; $display("FAIL reset pixel: got on=%b addr=%0d want 0/0", boss_on, rom_addr); end
    endtask

    // Entry descent: 52 ticks of 11 cycles until boss_y reaches HOME_Y
    task automatic test_enter();
        int cyc;
        speed_offset = 26'd3990;
        do_reset();
        cyc = 0;
        while (boss_y !== 10'(HOME_Y) && cyc < 2000) begin
            rand_inputs(50);
            run_cycle();
            cyc++;
            n_vec++; if (boss_y !== 10'(m_y) || boss_x !== 10'(m_x)) begin n_err++; $display("FAIL enter pos: got (%0d,%0d) want (%0d,%0d)", boss_x, boss_y, m_x, m_y); end
            n_vec++; if (health !== 10'(HP_INIT)) begin n_err++; $display("FAIL enter hit ignored: got %0d want %0d", health, HP_INIT); end
            n_vec++; if (boss_on !== e_on() || rom_addr !== 13'(e_addr())) begin n_err++; $display("FAIL enter pixel: got on=%b addr=%0d want %b/%0d", boss_on, rom_addr, e_on(), e_addr()); end
        end
        n_vec++; if (cyc != 52 * 11) begin n_err++; $display("FAIL enter duration: got %0d cycles want %0d", cyc, 52 * 11); end
    endtask

    // Random sweeping with sparse hits, full output comparison against the model
    task automatic test_sweep();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(15);
            run_cycle();
            n_vec++; if (boss_x !== 10'(m_x) || boss_y !== 10'(m_y)) begin n_err++; $display("FAIL sweep pos: got (%0d,%0d) want (%0d,%0d)", boss_x, boss_y, m_x, m_y); end
            n_vec++; if (health !== 10'(m_hp) || phase !== 1'(m_ph)) begin n_err++; $display("FAIL sweep hp/phase: got %0d/%b want %0d/%0d", health, phase, m_hp, m_ph); end
            n_vec++; if (fire_req !== 1'(m_fire) || die !== 1'b0) begin n_err++; $display("FAIL sweep fire/die: got %b/%b want %0d/0", fire_req, die, m_fire); end
            n_vec++; if (boss_on !== e_on() || rom_addr !== 13'(e_addr())) begin n_err++; $display("FAIL sweep pixel: got on=%b addr=%0d want %b/%0d", boss_on, rom_addr, e_on(), e_addr()); end
            n_vec++; if (boss_x > 10'd352 || boss_x < 10'd32) begin n_err++; $display("FAIL sweep limits: got %0d want 32..352", boss_x); end
        end
    endtask

    // Held hit for 20 cycles: counted at cycle offsets 0, 9 and 18
    task automatic test_hits();
        int guard, h0, want;
        is_hit = 1'b0; x = 10'd0; y = 10'd0;
        guard = 0;
        while (m_if != 0 && guard < 20) begin run_cycle(); guard++; end
        h0 = m_hp;
        is_hit = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            want = h0 - (i / 9 + 1);
            n_vec++; if (health !== 10'(want)) begin n_err++; $display("FAIL hits health@%0d: got %0d want %0d", i, health, want); end
        end
        is_hit = 1'b0;
        n_vec++; if (health !== 10'(h0 - 3)) begin n_err++; $display("FAIL hits total: got %0d want %0d", health, h0 - 3); end
    endtask

    // Phase 2: half health, double step, 16-tick volleys, right limit respected
    task automatic test_phase2();
        int guard, last_fire, nfire;
        x = 10'd0; y = 10'd0; rom_data = 12'h000; is_hit = 1'b1;
        guard = 0;
        while (m_hp > HP_INIT/2 && guard < 10000) begin
            run_cycle(); guard++;
            n_vec++; if (health !== 10'(m_hp)) begin n_err++; $display("FAIL p2 health: got %0d want %0d", health, m_hp); end
        end
        is_hit = 1'b0;
        n_vec++; if (guard >= 10000) begin n_err++; $display("FAIL p2 drain timeout: got hp %0d want %0d", health, HP_INIT/2); end
        guard = 0;
        while (phase !== 1'b1 && guard < 40) begin run_cycle(); guard++; end
        n_vec++; if (phase !== 1'b1 || guard > 11) begin n_err++; $display("FAIL p2 phase entry: got %b after %0d cycles want 1 within 11", phase, guard); end
        last_fire = -1; nfire = 0;
        for (int i = 0; i < 1200; i++) begin
            rand_inputs(0);
            run_cycle();
            n_vec++; if (boss_x !== 10'(m_x) || fire_req !== 1'(m_fire)) begin n_err++; $display("FAIL p2 x/fire: got %0d/%b want %0d/%0d", boss_x, fire_req, m_x, m_fire); end
            n_vec++; if (boss_x > 10'd352) begin n_err++; $display("FAIL p2 limit: got %0d want <=352", boss_x); end
            if (fire_req === 1'b1) begin
                nfire++;
                if (last_fire >= 0) begin
                    n_vec++; if (m_ticks - last_fire != 16) begin n_err++; $display("FAIL p2 fire period: got %0d want 16", m_ticks - last_fire); end
                end
                last_fire = m_ticks;
            end
        end
        n_vec++; if (nfire < 5) begin n_err++; $display("FAIL p2 fire count: got %0d want >=5", nfire); end
    endtask

    // Defeat: DYING on the next tick, blink, DEAD after DIE_TICKS ticks
    task automatic test_dying();
        int guard, t0, fx, fy;
        bit saw_on, saw_off;
        x = 10'd0; y = 10'd0; is_hit = 1'b1;
        guard = 0;
        while (m_hp > 0 && guard < 10000) begin run_cycle(); guard++; end
        is_hit = 1'b0;
        n_vec++; if (health !== 10'd0) begin n_err++; $display("FAIL dying health zero: got %0d want 0", health); end
        t0 = m_ticks;
        saw_on = 0; saw_off = 0; guard = 0;
        rom_data = 12'hF00;
        while (die !== 1'b1 && guard < DIE_TICKS * 11 + 40) begin
            x = 10'(m_x); y = 10'(m_y);
            run_cycle(); guard++;
            n_vec++; if (boss_on !== e_on() || boss_x !== 10'(m_x)) begin n_err++; $display("FAIL dying on/x: got %b/%0d want %b/%0d", boss_on, boss_x, e_on(), m_x); end
            if (m_st == S_DYING) begin
                if (boss_on === 1'b1) saw_on = 1; else saw_off = 1;
            end
        end
        n_vec++; if (die !== 1'b1 || m_ticks != t0 + 1 + DIE_TICKS) begin n_err++; $display("FAIL dying duration: got die=%b at tick %0d want 1 at %0d", die, m_ticks, t0 + 1 + DIE_TICKS); end
        n_vec++; if (!(saw_on && saw_off)) begin n_err++; $display("FAIL dying blink: got on=%0d off=%0d want both", saw_on, saw_off); end
        fx = m_x; fy = m_y;
        for (int i = 0; i < 60; i++) begin
            rand_inputs(50);
            run_cycle();
            n_vec++; if (boss_on !== 1'b0 || fire_req !== 1'b0 || die !== 1'b1) begin n_err++; $display("FAIL dead outputs: got on=%b fire=%b die=%b want 0/0/1", boss_on, fire_req, die); end
            n_vec++; if (boss_x !== 10'(fx) || boss_y !== 10'(fy)) begin n_err++; $display("FAIL dead frozen: got (%0d,%0d) want (%0d,%0d)", boss_x, boss_y, fx, fy); end
        end
    endtask

    // Asynchronous reset mid-DYING, then fast tick with clamped period
    task automatic test_reset_dying();
        int guard;
        speed_offset = 26'd5000;
        do_reset();
        x = 10'd0; y = 10'd0; rom_data = 12'h000; is_hit = 1'b1;
        guard = 0;
        while (m_st != S_DYING && guard < 12000) begin
            run_cycle(); guard++;
            n_vec++; if (health !== 10'(m_hp) || boss_x !== 10'(m_x)) begin n_err++; $display("FAIL rd drain: got %0d/%0d want %0d/%0d", health, boss_x, m_hp, m_x); end
        end
        is_hit = 1'b0;
        repeat (9) run_cycle();
        reset = 1'b1;
        model_reset();
        #1;
        n_vec++; if (boss_x !== 10'(HOME_X) || boss_y !== 10'(SPR_H/2)) begin n_err++; $display("FAIL rd pos: got (%0d,%0d) want (%0d,%0d)", boss_x, boss_y, HOME_X, SPR_H/2); end
        n_vec++; if (health !== 10'(HP_INIT) || phase !== 1'b0) begin n_err++; $display("FAIL rd hp/phase: got %0d/%b want %0d/0", health, phase, HP_INIT); end
        n_vec++; if (fire_req !== 1'b0 || die !== 1'b0 || boss_on !== 1'b0) begin n_err++; $display("FAIL rd flags: got fire=%b die=%b on=%b want 0/0/0", fire_req, die, boss_on); end
        @(negedge clk_in);
        reset = 1'b0;
        #1;
        for (int k = 1; k <= 12; k++) begin
            run_cycle();
            n_vec++; if (boss_y !== 10'(SPR_H/2 + k/2)) begin n_err++; $display("FAIL fast tick y@%0d: got %0d want %0d", k, boss_y, SPR_H/2 + k/2); end
        end
    endtask

    // Fixed pixel checks with the boss at (192,50)
    task automatic test_pixel();
        speed_offset = 26'd3990; is_hit = 1'b0; x = 10'd0; y = 10'd0; rom_data = 12'h000;
        do_reset();
        repeat (22) run_cycle();
        n_vec++; if (boss_x !== 10'd192 || boss_y !== 10'd50) begin n_err++; $display("FAIL pix pos: got (%0d,%0d) want (192,50)", boss_x, boss_y); end
        x = 10'd161; y = 10'd3; rom_data = 12'hCCC; #1;
        n_vec++; if (rom_addr !== 13'd0 || boss_on !== 1'b0) begin n_err++; $display("FAIL pix key: got addr=%0d on=%b want 0/0", rom_addr, boss_on); end
        rom_data = 12'hF00; #1;
        n_vec++; if (rom_addr !== 13'd0 || boss_on !== 1'b1) begin n_err++; $display("FAIL pix red: got addr=%0d on=%b want 0/1", rom_addr, boss_on); end
        x = 10'd160; #1;
        n_vec++; if (rom_addr !== 13'd0 || boss_on !== 1'b0) begin n_err++; $display("FAIL pix left edge: got addr=%0d on=%b want 0/0", rom_addr, boss_on); end
        x = 10'd224; y = 10'd98; #1;
        n_vec++; if (rom_addr !== 13'd6143 || boss_on !== 1'b1) begin n_err++; $display("FAIL pix corner: got addr=%0d on=%b want 6143/1", rom_addr, boss_on); end
        x = 10'd225; #1;
        n_vec++; if (rom_addr !== 13'd0 || boss_on !== 1'b0) begin n_err++; $display("FAIL pix right edge: got addr=%0d on=%b want 0/0", rom_addr, boss_on); end
        x = 10'd200; y = 10'd99; #1;
        n_vec++; if (rom_addr !== 13'd0 || boss_on !== 1'b0) begin n_err++; $display("FAIL pix bottom edge: got addr=%0d on=%b want 0/0", rom_addr, boss_on); end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_sweep();
        test_hits();
        test_phase2();
        test_dying();
        test_reset_dying();
        test_pixel();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
